bp_be_scoreboard_ni: RTL and testbench

- N-issue register scoreboard for the BE checker.
- Tracks outstanding writes per architectural register with saturating in-flight counters, so several writes to the same register can be in flight at once.
- Flags RAW/WAW hazards for every lane of an issue bundle, including hazards between lanes of the same bundle.
- Sits between the issue/dispatch stage and the writeback/commit paths; generalises the dual-issue scoreboard to issue_width_p lanes and clear_ports_p clear ports.

---
 rtl/bp_be_scoreboard_ni_if.sv | 29 ++
 rtl/bp_be_scoreboard_ni.sv | 84 ++++++++
 tb/tb_bp_be_scoreboard_ni.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/bp_be_scoreboard_ni_if.sv
// bp_be_scoreboard_ni_if: issue/writeback/hazard bundle between dispatch and the N-issue scoreboard.
interface bp_be_scoreboard_ni_if #(
    parameter int issue_width_p     = 2,
    parameter int clear_ports_p     = 2,
    parameter int num_rs_p          = 2,
    parameter int reg_addr_width_gp = 5
);
    localparam int rf_els_lp = 1 << reg_addr_width_gp;
    logic [issue_width_p-1:0]                                 score_v_i;
    logic [issue_width_p-1:0][reg_addr_width_gp-1:0]          score_rd_i;
    logic [clear_ports_p-1:0]                                 clear_v_i;
    logic [clear_ports_p-1:0][reg_addr_width_gp-1:0]          clear_rd_i;
    logic [issue_width_p-1:0][num_rs_p-1:0][reg_addr_width_gp-1:0] rs_i;
    logic [issue_width_p-1:0]                                 rd_v_i;
    logic [issue_width_p-1:0][reg_addr_width_gp-1:0]          rd_i;
    logic [issue_width_p-1:0][num_rs_p-1:0]                   rs_match_o;
    logic [issue_width_p-1:0]                                 rd_match_o;
    logic                                                     stall_o;
    logic [rf_els_lp-1:0]                                     busy_o;
    logic                                                     err_o;
    modport master (
        output score_v_i, score_rd_i, clear_v_i, clear_rd_i, rs_i, rd_v_i, rd_i,
        input  rs_match_o, rd_match_o, stall_o, busy_o, err_o
    );
    modport slave (
        input  score_v_i, score_rd_i, clear_v_i, clear_rd_i, rs_i, rd_v_i, rd_i,
        output rs_match_o, rd_match_o, stall_o, busy_o, err_o
    );
endinterface

// File: rtl/bp_be_scoreboard_ni.sv
// bp_be_scoreboard_ni: N-issue register scoreboard with saturating in-flight counters and RAW/WAW checks.
// Optional BP_BE_SCOREBOARD_CLEAR_BYPASS_EN lets a same-cycle final clear release dependents.
module bp_be_scoreboard_ni #(
    parameter int issue_width_p     = 2,
    parameter int clear_ports_p     = 2,
    parameter int num_rs_p          = 2,
    parameter int cnt_width_p       = 2,
    parameter int reg_addr_width_gp = 5
) (
    input logic clk_i,
    input logic reset_n_i,
    bp_be_scoreboard_ni_if.slave sb
);
    localparam int rf_els_lp = 1 << reg_addr_width_gp;
    localparam int sw_lp = cnt_width_p + $clog2(issue_width_p + clear_ports_p + 1) + 1;
    localparam logic [sw_lp-1:0] max_lp = sw_lp'((1 << cnt_width_p) - 1);

    logic [cnt_width_p-1:0] cnt_r [rf_els_lp];
    logic [cnt_width_p-1:0] nxt [rf_els_lp];
    logic [sw_lp-1:0] s [rf_els_lp];
    logic [sw_lp-1:0] c [rf_els_lp];
    logic [sw_lp-1:0] avail [rf_els_lp];
    logic [rf_els_lp-1:0] busy, busy_m;
    logic [issue_width_p-1:0][num_rs_p-1:0] rs_match;
    logic [issue_width_p-1:0] rd_match;
    logic stall, under, err_r;

    always_comb begin
        stall = 1'b0;
        under = 1'b0;
        for (int r = 0; r < rf_els_lp; r++) begin
            s[r] = '0;
            c[r] = '0;
            for (int i = 0; i < issue_width_p; i++)
                s[r] = s[r] + sw_lp'(r != 0 && sb.score_v_i[i] && sb.score_rd_i[i] == reg_addr_width_gp'(r));
            for (int p = 0; p < clear_ports_p; p++)
                c[r] = c[r] + sw_lp'(r != 0 && sb.clear_v_i[p] && sb.clear_rd_i[p] == reg_addr_width_gp'(r));
            stall = stall | (sw_lp'(cnt_r[r]) + s[r] > max_lp + c[r]);
        end
        // the whole bundle is dropped on stall, so availability is computed after the decision
        for (int r = 0; r < rf_els_lp; r++) begin
            avail[r] = sw_lp'(cnt_r[r]) + (stall ? '0 : s[r]);
            under = under | (c[r] > avail[r]);
            nxt[r] = cnt_width_p'(avail[r] - ((c[r] > avail[r]) ? avail[r] : c[r]));
            busy[r] = cnt_r[r] != '0;
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
            busy_m[r] = busy[r] && (sw_lp'(cnt_r[r]) != c[r]);
`else
            busy_m[r] = busy[r];
`endif
        end
    end

    always_comb begin
        for (int j = 0; j < issue_width_p; j++) begin
            for (int k = 0; k < num_rs_p; k++) begin
                rs_match[j][k] = busy_m[sb.rs_i[j][k]];
                for (int i = 0; i < j; i++)
                    rs_match[j][k] = rs_match[j][k] | (sb.rd_v_i[i] && sb.rd_i[i] == sb.rs_i[j][k]);
                rs_match[j][k] = rs_match[j][k] && sb.rs_i[j][k] != '0;
            end
            rd_match[j] = busy_m[sb.rd_i[j]];
            for (int i = 0; i < j; i++)
                rd_match[j] = rd_match[j] | (sb.rd_v_i[i] && sb.rd_i[i] == sb.rd_i[j]);
            rd_match[j] = rd_match[j] && sb.rd_v_i[j] && sb.rd_i[j] != '0;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int r = 0; r < rf_els_lp; r++) cnt_r[r] <= '0;
            err_r <= 1'b0;
        end else begin
            for (int r = 0; r < rf_els_lp; r++) cnt_r[r] <= nxt[r];
            err_r <= err_r | under;
        end
    end

    assign sb.rs_match_o = rs_match;
    assign sb.rd_match_o = rd_match;
    assign sb.stall_o    = stall;
    assign sb.busy_o     = busy;
    assign sb.err_o      = err_r;
endmodule

// File: tb/tb_bp_be_scoreboard_ni.sv
// tb_bp_be_scoreboard_ni: directed-vector check of scoring, clearing, hazards, saturation and reset.
module tb_bp_be_scoreboard_ni;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    bp_be_scoreboard_ni_if #(.issue_width_p(2), .clear_ports_p(2), .num_rs_p(2), .reg_addr_width_gp(5)) sb_if ();

    bp_be_scoreboard_ni #(.issue_width_p(2), .clear_ports_p(2), .num_rs_p(2), .cnt_width_p(2), .reg_addr_width_gp(5)) dut (
        .clk_i(clk),
        .reset_n_i(rst_n),
        .sb(sb_if)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        sb_if.score_v_i = '0; sb_if.score_rd_i = '0;
        sb_if.clear_v_i = '0; sb_if.clear_rd_i = '0;
        sb_if.rs_i = '0; sb_if.rd_v_i = '0; sb_if.rd_i = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        #2;
        chk("reset_busy", sb_if.busy_o, 32'h0);
        chk("reset_err", {31'b0, sb_if.err_o}, 32'h0);
        chk("reset_stall", {31'b0, sb_if.stall_o}, 32'h0);
        chk("reset_rs_match", {28'b0, sb_if.rs_match_o}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        // single score of x5, visible one cycle later
        sb_if.score_v_i = 2'b01; sb_if.score_rd_i[0] = 5'd5;
        #1;
        chk("score_stall", {31'b0, sb_if.stall_o}, 32'h0);
        chk("score_not_yet_busy", sb_if.busy_o, 32'h0);
        tick(); idle();
        sb_if.rs_i[0][0] = 5'd5; sb_if.rd_v_i = 2'b01; sb_if.rd_i[0] = 5'd5;
        #1;
        chk("busy5", sb_if.busy_o, 32'h20);
        chk("raw5", {28'b0, sb_if.rs_match_o}, 32'h1);
        chk("waw5", {30'b0, sb_if.rd_match_o}, 32'h1);
        tick(); tick(); idle();
        // clear and read x5 in the same cycle
        sb_if.clear_v_i = 2'b01; sb_if.clear_rd_i[0] = 5'd5; sb_if.rs_i[0][0] = 5'd5;
        #1;
`ifdef BP_BE_SCOREBOARD_CLEAR_BYPASS_EN
        chk("clear5_same_cycle", {28'b0, sb_if.rs_match_o}, 32'h0);
`else
        chk("clear5_same_cycle", {28'b0, sb_if.rs_match_o}, 32'h1);
`endif
        tick(); idle();
        sb_if.rs_i[0][0] = 5'd5;
        #1;
        chk("clear5_busy", sb_if.busy_o, 32'h0);
        chk("clear5_raw", {28'b0, sb_if.rs_match_o}, 32'h0);
        // intra-bundle RAW/WAW against an empty table
        idle();
        sb_if.rd_v_i = 2'b11; sb_if.rd_i[0] = 5'd7; sb_if.rd_i[1] = 5'd7; sb_if.rs_i[1][1] = 5'd7;
        #1;
        chk("bundle_raw", {28'b0, sb_if.rs_match_o}, 32'h8);
        chk("bundle_waw", {30'b0, sb_if.rd_match_o}, 32'h2);
        // saturate x9 at 3
        idle();
        sb_if.score_v_i = 2'b01; sb_if.score_rd_i[0] = 5'd9;
        tick(); tick(); tick(); idle();
        #1;
        chk("sat_busy9", sb_if.busy_o, 32'h200);
        sb_if.score_v_i = 2'b11; sb_if.score_rd_i[0] = 5'd9; sb_if.score_rd_i[1] = 5'd4;
        #1;
        chk("sat_stall", {31'b0, sb_if.stall_o}, 32'h1);
        tick();
        chk("sat_not_applied", sb_if.busy_o, 32'h200);
        sb_if.clear_v_i = 2'b01; sb_if.clear_rd_i[0] = 5'd9;
        #1;
        chk("sat_clear_unstall", {31'b0, sb_if.stall_o}, 32'h0);
        tick(); idle();
        #1;
        chk("sat_applied", sb_if.busy_o, 32'h210);
        sb_if.clear_v_i = 2'b11; sb_if.clear_rd_i[0] = 5'd9; sb_if.clear_rd_i[1] = 5'd9;
        tick(); idle();
        #1;
        chk("sat_cnt9_left1", sb_if.busy_o, 32'h210);
        sb_if.clear_v_i = 2'b11; sb_if.clear_rd_i[0] = 5'd9; sb_if.clear_rd_i[1] = 5'd4;
        tick(); idle();
        #1;
        chk("sat_drained", sb_if.busy_o, 32'h0);
        chk("sat_no_err", {31'b0, sb_if.err_o}, 32'h0);
        // x0 is inert
        sb_if.score_v_i = 2'b11; sb_if.clear_v_i = 2'b11; sb_if.rd_v_i = 2'b11;
        #1;
        chk("x0_stall", {31'b0, sb_if.stall_o}, 32'h0);
        chk("x0_rs_match", {28'b0, sb_if.rs_match_o}, 32'h0);
        chk("x0_rd_match", {30'b0, sb_if.rd_match_o}, 32'h0);
        tick(); idle();
        #1;
        chk("x0_busy", sb_if.busy_o, 32'h0);
        chk("x0_err", {31'b0, sb_if.err_o}, 32'h0);
        // score and clear of x6 in one cycle net out
        sb_if.score_v_i = 2'b01; sb_if.score_rd_i[0] = 5'd6;
        sb_if.clear_v_i = 2'b01; sb_if.clear_rd_i[0] = 5'd6;
        tick(); idle();
        #1;
        chk("net_busy", sb_if.busy_o, 32'h0);
        chk("net_err", {31'b0, sb_if.err_o}, 32'h0);
        // underflow on x12
        sb_if.clear_v_i = 2'b01; sb_if.clear_rd_i[0] = 5'd12;
        #1;
        chk("under_err_pre", {31'b0, sb_if.err_o}, 32'h0);
        tick(); idle();
        #1;
        chk("under_err", {31'b0, sb_if.err_o}, 32'h1);
        chk("under_busy", sb_if.busy_o, 32'h0);
        tick();
        chk("under_err_held", {31'b0, sb_if.err_o}, 32'h1);
        // cnt[5]=2 from one bundle, then async reset mid-cycle
        sb_if.score_v_i = 2'b11; sb_if.score_rd_i[0] = 5'd5; sb_if.score_rd_i[1] = 5'd5;
        tick(); idle();
        chk("dual_busy5", sb_if.busy_o, 32'h20);
        #1 rst_n = 1'b0;
        #1;
        chk("async_busy", sb_if.busy_o, 32'h0);
        chk("async_err", {31'b0, sb_if.err_o}, 32'h0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_reset_busy", sb_if.busy_o, 32'h0);
        chk("post_reset_err", {31'b0, sb_if.err_o}, 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
